march_controller: RTL

Per-ray sequencer for the scene SDF query unit. It accepts one ray (origin, direction, object select), iterates sphere-tracing steps, and ends each ray as a hit, a miss or an error. Each step computes the sample point, issues one query to the scene query unit, waits for the distance and advances the ray. It sits between the per-pixel ray generator and the scene query unit, and holds the query unit's object select stable for the whole ray.

---
 rtl/march_controller.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/march_controller.sv
// march_controller: per-ray sphere-tracing sequencer in front of the scene SDF query unit.
// Latency: 3+L cycles per step (CALC, ISSUE, L WAIT, EVAL), plus the accept and DONE cycles.
// Backpressure: start is taken only while ready (IDLE); one query in flight, bounded by TIMEOUT.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start/ready              ray request handshake; origin, dir, obj_sel sampled on accept
//   q_valid, q_pos, q_obj_sel  query strobe, sample point, object select to the query unit
//   q_dist, q_done           query result and its strobe (honoured in WAIT only)
//   done, hit, err           end-of-ray pulse and outcome flags
//   t_out, steps, hit_pos    final ray parameter, queries issued, last sample point
// Fixed point is signed Q8.24; a vec3 is packed {x, y, z}, x in the top 32 bits.
`timescale 1ns/1ps

module march_controller #(
  parameter int          MAX_STEPS = 64,
  parameter int          STEP_W    = 8,
  parameter logic [31:0] EPSILON   = 32'h00004189,
  parameter logic [31:0] MAX_DIST  = 32'h14000000,
  parameter int          TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              ready,
  input  logic [95:0]       origin,
  input  logic [95:0]       dir,
  input  logic              obj_sel,
  output logic              q_valid,
  output logic [95:0]       q_pos,
  output logic              q_obj_sel,
  input  logic [31:0]       q_dist,
  input  logic              q_done,
  output logic              done,
  output logic              hit,
  output logic              err,
  output logic [31:0]       t_out,
  output logic [STEP_W-1:0] steps,
  output logic [95:0]       hit_pos
);

  typedef enum logic [2:0] {IDLE, CALC, ISSUE, WAIT, EVAL, DONE} state_t;

  localparam int WC_W = $clog2(TIMEOUT + 1);

  state_t          state, state_nxt;
  logic [95:0]     org_r, dir_r;
  logic [31:0]     t_r, dist_r;
  logic [WC_W-1:0] wcnt;
  logic [95:0]     calc_pos;
  logic [32:0]     t_sum;
  logic [31:0]     t_sat;
  logic            is_hit, past_max, at_limit, timed_out;

  // Q8.24 multiply: bits [55:24] of the full signed product (truncating).
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] ae, be;
    ae = {{32{a[31]}}, a};
    be = {{32{b[31]}}, b};
    return 32'((ae * be) >> 24);
  endfunction

  // Sample point origin + t*dir; component additions wrap.
  assign calc_pos = {org_r[95:64] + fmul(t_r, dir_r[95:64]),
                     org_r[63:32] + fmul(t_r, dir_r[63:32]),
                     org_r[31:0]  + fmul(t_r, dir_r[31:0])};

  // t and dist_r are both non-negative whenever the sum is used, so any
  // carry into bit 31 or above means overflow past the largest positive value.
  assign t_sum     = {1'b0, t_r} + {1'b0, dist_r};
  assign t_sat     = (t_sum[32:31] != 2'b00) ? 32'h7FFFFFFF : t_sum[31:0];
  assign is_hit    = $signed(dist_r) < $signed(EPSILON);
  assign past_max  = $signed(t_sat) > $signed(MAX_DIST);
  assign at_limit  = steps == STEP_W'(MAX_STEPS);
  // The counter reads TIMEOUT-1 on the TIMEOUT-th silent WAIT cycle.
  assign timed_out = wcnt == WC_W'(TIMEOUT - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    q_valid   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = CALC;
      end
      CALC:  state_nxt = ISSUE;
      ISSUE: begin
        q_valid   = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (q_done)         state_nxt = EVAL;
        else if (timed_out) state_nxt = DONE;
      end
      EVAL: begin
        if (is_hit || past_max || at_limit) state_nxt = DONE;
        else                                state_nxt = CALC;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Result registers are loaded on the transition into DONE so they are
  // already valid while done is high, and they hold until the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      org_r     <= '0;
      dir_r     <= '0;
      t_r       <= '0;
      dist_r    <= '0;
      wcnt      <= '0;
      q_pos     <= '0;
      q_obj_sel <= 1'b0;
      hit       <= 1'b0;
      err       <= 1'b0;
      t_out     <= '0;
      steps     <= '0;
      hit_pos   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            org_r     <= origin;
            dir_r     <= dir;
            q_obj_sel <= obj_sel;
            t_r       <= '0;
            steps     <= '0;
            hit       <= 1'b0;
            err       <= 1'b0;
            t_out     <= '0;
            hit_pos   <= '0;
          end
        end
        CALC: q_pos <= calc_pos;
        ISSUE: begin
          steps <= steps + 1'b1;
          wcnt  <= '0;
        end
        WAIT: begin
          if (q_done) begin
            dist_r <= q_dist;
          end else begin
            wcnt <= wcnt + 1'b1;
            if (timed_out) begin
              err     <= 1'b1;
              hit     <= 1'b0;
              t_out   <= t_r;
              hit_pos <= q_pos;
            end
          end
        end
        EVAL: begin
          if (is_hit) begin
            hit     <= 1'b1;
            t_out   <= t_r;
            hit_pos <= q_pos;
          end else begin
            t_r <= t_sat;
            if (past_max || at_limit) begin
              t_out   <= t_sat;
              hit_pos <= q_pos;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
